// File: rtl/calc_pkg.sv
// Shared types for the calc_engine slice: operation codes, FSM states and
// a helper that classifies the ops served by the sequential divider.
package calc_pkg;

  localparam logic [2:0] NOP_CODE_A = 3'b110;
  localparam logic [2:0] NOP_CODE_B = 3'b111;

  typedef enum logic [2:0] {
    OP_ADD     = 3'b000,
    OP_SUB     = 3'b001,
    OP_MUL     = 3'b010,
    OP_DIV     = 3'b011,
    OP_MOD     = 3'b100,
    OP_SQR     = 3'b101,
    OP_NOP     = NOP_CODE_A,
    OP_NOP_ALT = NOP_CODE_B
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic logic is_div_op(input op_e op_i);
    return (op_i == OP_DIV) || (op_i == OP_MOD);
  endfunction

endpackage

// File: rtl/calc_div_seq.sv
// Unsigned W-bit restoring divider producing one quotient bit per clock.
// valid rises after the W-th iteration and holds until the next load/abort.
module calc_div_seq #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         abort,
  input  logic         load,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         valid
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;
  logic          valid_q, valid_d;
  logic [W:0]    trial;
  logic [W-1:0]  diff;
  logic          fits;

  always_comb begin
    // Shift the next dividend bit into the partial remainder and try to subtract.
    trial   = {rem_q, quo_q[W-1]};
    fits    = (trial >= {1'b0, dvs_q});
    diff    = trial[W-1:0] - dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    valid_d = valid_q;
    if (abort) begin
      run_d   = 1'b0;
      valid_d = 1'b0;
    end else if (load) begin
      rem_d   = '0;
      quo_d   = dividend;
      dvs_d   = divisor;
      cnt_d   = '0;
      run_d   = 1'b1;
      valid_d = 1'b0;
    end else if (run_q) begin
      rem_d = fits ? diff : trial[W-1:0];
      quo_d = {quo_q[W-2:0], fits};
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(W - 1)) begin
        run_d   = 1'b0;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      valid_q <= valid_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign valid     = valid_q;

endmodule

// File: rtl/calc_engine.sv
// Accumulating calculator: ADD/SUB/MUL in one EXEC cycle, DIV/MOD through a
// shared sequential divider. Define CALC_ENGINE_SQR_EN to enable op 101 (square).
module calc_engine
  import calc_pkg::*;
#(
  parameter int W    = 32,
  parameter int IN_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            clear,
  input  logic [2:0]      op,
  input  logic [IN_W-1:0] a,
  input  logic [IN_W-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [W-1:0]    result,
  output logic            ovf,
  output logic            dz,
  output state_e          dbg_state
);

  // Handshake: start is a one-cycle request taken only in IDLE with clear low
  // (otherwise dropped, never queued); done pulses once, in the cycle that
  // result/ovf/dz first show the new values. There is no back-pressure.

  state_e       state_q, state_d;
  op_e          op_q, op_d;
  logic [W-1:0] lhs_q, lhs_d;
  logic [W-1:0] rhs_q, rhs_d;
  logic [W-1:0] result_q, result_d;
  logic         chain_q, chain_d;
  logic         ovf_q, ovf_d;
  logic         dz_q, dz_d;

  op_e          op_in;
  logic [W-1:0] left, rhs_in, mul_rhs;
  logic         accept, div_go;
  logic [W:0]   sum;
  logic [2*W-1:0] prod;
  logic [W-1:0] exec_res;
  logic         exec_ovf, exec_dz, exec_chain;
  logic [W-1:0] div_quo, div_rem;
  logic         div_valid;

  assign op_in  = op_e'(op);
  assign left   = chain_q ? result_q : W'(a);
  assign rhs_in = W'(b);
  assign accept = (state_q == S_IDLE) && start && !clear;
  assign div_go = accept && is_div_op(op_in) && (b != '0);

  calc_div_seq #(.W(W)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .abort     (clear),
    .load      (div_go),
    .dividend  (left),
    .divisor   (rhs_in),
    .quotient  (div_quo),
    .remainder (div_rem),
    .valid     (div_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (accept) state_d = div_go ? S_DIV : S_EXEC;
        S_EXEC: state_d = S_DONE;
        S_DIV:  if (div_valid) state_d = S_DONE;
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE) && !clear;
    dbg_state = state_q;
  end

`ifdef CALC_ENGINE_SQR_EN
  assign mul_rhs = (op_q == OP_SQR) ? lhs_q : rhs_q;
`else
  assign mul_rhs = rhs_q;
`endif

  always_comb begin
    sum        = {1'b0, lhs_q} + {1'b0, rhs_q};
    prod       = (2*W)'(lhs_q) * (2*W)'(mul_rhs);
    exec_res   = result_q;
    exec_ovf   = 1'b0;
    exec_dz    = 1'b0;
    exec_chain = 1'b1;
    case (op_q)
      OP_ADD: begin
        exec_res = sum[W-1:0];
        exec_ovf = sum[W];
      end
      OP_SUB: begin
        exec_res = lhs_q - rhs_q;
        exec_ovf = (lhs_q < rhs_q);
      end
      OP_MUL: begin
        exec_res = prod[W-1:0];
        exec_ovf = |prod[2*W-1:W];
      end
`ifdef CALC_ENGINE_SQR_EN
      OP_SQR: begin
        exec_res = prod[W-1:0];
        exec_ovf = |prod[2*W-1:W];
      end
`endif
      // Only a zero divisor reaches EXEC for DIV/MOD.
      OP_DIV, OP_MOD: begin
        exec_dz    = 1'b1;
        exec_chain = chain_q;
      end
      default: exec_chain = chain_q;
    endcase
  end

  always_comb begin
    op_d     = op_q;
    lhs_d    = lhs_q;
    rhs_d    = rhs_q;
    result_d = result_q;
    chain_d  = chain_q;
    ovf_d    = ovf_q;
    dz_d     = dz_q;
    if (clear) begin
      result_d = '0;
      chain_d  = 1'b0;
      ovf_d    = 1'b0;
      dz_d     = 1'b0;
    end else if (accept) begin
      op_d  = op_in;
      lhs_d = left;
      rhs_d = rhs_in;
    end else if (state_q == S_EXEC) begin
      result_d = exec_res;
      chain_d  = exec_chain;
      ovf_d    = exec_ovf;
      dz_d     = exec_dz;
    end else if ((state_q == S_DIV) && div_valid) begin
      result_d = (op_q == OP_MOD) ? div_rem : div_quo;
      chain_d  = 1'b1;
      ovf_d    = 1'b0;
      dz_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_NOP;
      lhs_q    <= '0;
      rhs_q    <= '0;
      result_q <= '0;
      chain_q  <= 1'b0;
      ovf_q    <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      op_q     <= op_d;
      lhs_q    <= lhs_d;
      rhs_q    <= rhs_d;
      result_q <= result_d;
      chain_q  <= chain_d;
      ovf_q    <= ovf_d;
      dz_q     <= dz_d;
    end
  end

  assign result = result_q;
  assign ovf    = ovf_q;
  assign dz     = dz_q;

endmodule

// File: tb/tb_calc_engine.sv
// Directed bench for calc_engine: reset, chained arithmetic, divider timing,
// divide-by-zero, NOP, start-while-busy, clear and reset aborts, optional square.
module tb_calc_engine;
  import calc_pkg::*;

  localparam int W       = 32;
  localparam int IN_W    = 8;
  localparam int FAST    = 2;
  localparam int DIV_LAT = W + 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            clear;
  logic [2:0]      op;
  logic [IN_W-1:0] a;
  logic [IN_W-1:0] b;
  logic            busy;
  logic            done;
  logic [W-1:0]    result;
  logic            ovf;
  logic            dz;
  state_e          dbg_state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  calc_engine #(.W(W), .IN_W(IN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .clear     (clear),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .ovf       (ovf),
    .dz        (dz),
    .dbg_state (dbg_state)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Issue one op; latency counts clock edges from the accept edge (inclusive)
  // up to the edge after which done is seen.
  task automatic run_op(input string tag, input logic [2:0] op_i, input logic [IN_W-1:0] a_i,
                        input logic [IN_W-1:0] b_i, input int exp_lat, input logic [W-1:0] exp_res,
                        input logic exp_ovf, input logic exp_dz);
    int   lat;
    logic busy_ok;
    @(negedge clk);
    start = 1'b1;
    op    = op_i;
    a     = a_i;
    b     = b_i;
    @(negedge clk);
    start   = 1'b0;
    a       = IN_W'($urandom_range(0, 255));
    b       = IN_W'($urandom_range(0, 255));
    lat     = 1;
    busy_ok = 1'b1;
    while (!done && lat < 100) begin
      busy_ok &= busy;
      @(negedge clk);
      lat++;
    end
    busy_ok &= busy;
    check({tag, " latency"}, W'(lat), W'(exp_lat));
    check({tag, " busy"}, W'(busy_ok), W'(1));
    check({tag, " result"}, result, exp_res);
    check({tag, " ovf"}, W'(ovf), W'(exp_ovf));
    check({tag, " dz"}, W'(dz), W'(exp_dz));
    @(negedge clk);
    check({tag, " done_one_cycle"}, W'({done, busy}), W'(0));
  endtask

  task automatic pulse_clear(input string tag);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check({tag, " result"}, result, '0);
    check({tag, " flags"}, W'({ovf, dz, busy, done}), W'(0));
    check({tag, " state"}, W'(dbg_state), W'(S_IDLE));
  endtask

  task automatic watch_no_done(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      seen |= done;
    end
    check(tag, W'(seen), W'(0));
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0;
    start = 1'b0;
    clear = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    check("reset result", result, '0);
    check("reset flags", W'({ovf, dz, busy, done}), W'(0));
    check("reset state", W'(dbg_state), W'(S_IDLE));
    rst_n = 1'b1;

    run_op("add_fresh", OP_ADD, 8'h05, 8'h03, FAST, 32'h0000_0008, 1'b0, 1'b0);
    run_op("sub_borrow", OP_SUB, 8'hEE, 8'h09, FAST, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op("add_wrap", OP_ADD, 8'h44, 8'h01, FAST, 32'h0000_0000, 1'b1, 1'b0);
    run_op("add_chain_zero", OP_ADD, 8'h55, 8'h02, FAST, 32'h0000_0002, 1'b0, 1'b0);
    pulse_clear("clear1");

    run_op("add_fresh2", OP_ADD, 8'h05, 8'h03, FAST, 32'h0000_0008, 1'b0, 1'b0);
    run_op("mul_chain", OP_MUL, 8'hAA, 8'h10, FAST, 32'h0000_0080, 1'b0, 1'b0);
    run_op("div_chain", OP_DIV, 8'h11, 8'h03, DIV_LAT, 32'h0000_002A, 1'b0, 1'b0);
    run_op("mod_zero", OP_MOD, 8'h11, 8'h00, FAST, 32'h0000_002A, 1'b0, 1'b1);
    run_op("mod_chain", OP_MOD, 8'h11, 8'h05, DIV_LAT, 32'h0000_0002, 1'b0, 1'b0);
    run_op("nop", 3'b110, 8'h33, 8'h44, FAST, 32'h0000_0002, 1'b0, 1'b0);
    run_op("add_after_nop", OP_ADD, 8'h77, 8'h01, FAST, 32'h0000_0003, 1'b0, 1'b0);
    run_op("div_to_zero", OP_DIV, 8'h00, 8'h07, DIV_LAT, 32'h0000_0000, 1'b0, 1'b0);
    run_op("add_after_zero", OP_ADD, 8'h99, 8'h04, FAST, 32'h0000_0004, 1'b0, 1'b0);
    run_op("nop_alt", 3'b111, 8'h12, 8'h34, FAST, 32'h0000_0004, 1'b0, 1'b0);

    // Start a divide, poke start mid-way, then abort it with clear in DIV cycle 5.
    seen = 1'b0;
    @(negedge clk);
    start = 1'b1;
    op    = OP_DIV;
    b     = 8'h03;
    @(negedge clk);
    start = 1'b0;
    seen |= done;
    @(negedge clk);
    start = 1'b1;
    op    = OP_ADD;
    a     = 8'h01;
    b     = 8'h01;
    seen |= done;
    @(negedge clk);
    start = 1'b0;
    seen |= done;
    check("ignored_start state", W'(dbg_state), W'(S_DIV));
    check("ignored_start busy", W'(busy), W'(1));
    @(negedge clk);
    seen |= done;
    @(negedge clk);
    clear = 1'b1;
    seen |= done;
    @(negedge clk);
    clear = 1'b0;
    check("abort state", W'(dbg_state), W'(S_IDLE));
    check("abort result", result, '0);
    check("abort flags", W'({ovf, dz, busy, done, seen}), W'(0));
    watch_no_done("abort no_done", W + 5);
    run_op("add_after_abort", OP_ADD, 8'h07, 8'h01, FAST, 32'h0000_0008, 1'b0, 1'b0);

    // Reset in the middle of a divide must discard it.
    @(negedge clk);
    start = 1'b1;
    op    = OP_DIV;
    b     = 8'h02;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset state", W'(dbg_state), W'(S_IDLE));
    check("midreset result", result, '0);
    check("midreset flags", W'({ovf, dz, busy, done}), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    watch_no_done("midreset no_done", W + 5);
    run_op("add_after_reset", OP_ADD, 8'h05, 8'h03, FAST, 32'h0000_0008, 1'b0, 1'b0);

    pulse_clear("clear2");
`ifdef CALC_ENGINE_SQR_EN
    run_op("sqr_fresh", OP_SQR, 8'hFF, 8'h12, FAST, 32'h0000_FE01, 1'b0, 1'b0);
    run_op("sub_after_sqr", OP_SUB, 8'h00, 8'h01, FAST, 32'h0000_FE00, 1'b0, 1'b0);
    run_op("sqr_chain", OP_SQR, 8'h03, 8'h12, FAST, 32'hFC04_0000, 1'b0, 1'b0);
`else
    run_op("sqr_as_nop", OP_SQR, 8'hFF, 8'h12, FAST, 32'h0000_0000, 1'b0, 1'b0);
    run_op("sub_fresh", OP_SUB, 8'h00, 8'h01, FAST, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op("sqr_nop_hold", OP_SQR, 8'h03, 8'h12, FAST, 32'hFFFF_FFFF, 1'b0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
